// File: rtl/mem_stream_reader.sv
// Burst read engine for a 1-cycle-latency memory read port, with a 2-entry skid buffer
// feeding a valid/ready stream that carries a last-beat marker and a completion pulse.
module mem_stream_reader #(
  parameter int unsigned MEM_WIDTH_BYTES = 8,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned LEN_WIDTH       = 16,
  localparam int unsigned DW             = MEM_WIDTH_BYTES * 8,
  localparam int unsigned AW             = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic [AW-1:0]        req_addr_in,
  input  logic [LEN_WIDTH-1:0] req_len_in,
  output logic [AW-1:0]        mem_read_addr_out,
  output logic                 mem_read_out,
  input  logic [DW-1:0]        mem_read_data_in,
  output logic                 out_valid_out,
  input  logic                 out_ready_in,
  output logic [DW-1:0]        out_data_out,
  output logic                 out_last_out,
  output logic                 done_out,
  input  logic                 debugen_in
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e               state_q;
  logic [AW-1:0]        addr_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic [DW-1:0]        buf_data_q [2];
  logic [1:0]           buf_last_q;
  logic                 head_q;
  logic [1:0]           count_q;
  logic                 done_q;

  logic          pop;
  logic          push;
  logic          issue;
  logic          tail;
  logic [2:0]    occ;
  logic [1:0]    count_next;
  logic [AW-1:0] addr_next;

  always_comb begin
    pop        = (count_q != 2'd0) && out_ready_in;
    push       = inflight_q;
    // Buffered plus in-flight words after this cycle's pop; a new read must still fit.
    occ        = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    issue      = (state_q == StIssue) && (occ < 3'd2);
    tail       = head_q ^ count_q[0];
    count_next = count_q + {1'b0, push} - {1'b0, pop};
    addr_next  = (addr_q == AW'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
  end

  assign req_ready_out     = (state_q == StIdle);
  assign mem_read_out      = issue;
  assign mem_read_addr_out = addr_q;
  assign out_valid_out     = (count_q != 2'd0);
  assign out_data_out      = buf_data_q[head_q];
  assign out_last_out      = buf_last_q[head_q];
  assign done_out          = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
      end
      buf_last_q      <= '0;
      head_q          <= 1'b0;
      count_q         <= '0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == LEN_WIDTH'(1));
      if (push) begin
        buf_data_q[tail] <= mem_read_data_in;
        buf_last_q[tail] <= inflight_last_q;
      end
      count_q <= count_next;
      if (pop) begin
        head_q <= ~head_q;
      end
      if (issue) begin
        addr_q      <= addr_next;
        remaining_q <= remaining_q - 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (req_valid_in) begin
            if (req_len_in == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q      <= req_addr_in;
              remaining_q <= req_len_in;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          if (issue && (remaining_q == LEN_WIDTH'(1))) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // The final beat leaves the buffer this cycle with nothing left behind it.
          if (!inflight_q && (count_next == 2'd0)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (debugen_in && !reset) begin
      if (req_valid_in && req_ready_out) begin
        $write("[msr] req addr=%0d len=%0d\n", req_addr_in, req_len_in);
      end
      if (issue) begin
        $write("[msr] issue addr=%0d remaining=%0d\n", addr_q, remaining_q);
      end
      if (pop) begin
        $write("[msr] beat data=%0h last=%0b\n", out_data_out, out_last_out);
      end
      if (done_q) begin
        $write("[msr] done\n");
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: directed and random bursts against a queue
// model of expected beats, with a 1-cycle registered memory model on the read port.
module tb_mem_stream_reader;

  localparam int unsigned DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic [15:0] req_len;
  logic [9:0]  mem_read_addr;
  logic        mem_read;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        done;
  logic        debugen;

  logic [63:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  mem_stream_reader #(
    .MEM_WIDTH_BYTES(8),
    .MEM_DEPTH      (DEPTH),
    .LEN_WIDTH      (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_in     (req_valid),
    .req_ready_out    (req_ready),
    .req_addr_in      (req_addr),
    .req_len_in       (req_len),
    .mem_read_addr_out(mem_read_addr),
    .mem_read_out     (mem_read),
    .mem_read_data_in (mem_rdata),
    .out_valid_out    (out_valid),
    .out_ready_in     (out_ready),
    .out_data_out     (out_data),
    .out_last_out     (out_last),
    .done_out         (done),
    .debugen_in       (debugen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_read_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 always ready, 1 pattern 1,0,0,1,0,1, 2 stalled for 10 cycles, 3 random.
  // abort_after > 0 returns (mid-burst) once that many beats were accepted.
  task automatic run_burst(input int a, input int len, input int mode, input int abort_after);
    logic [63:0] exp_q[$];
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          issued = 0;
    int          popped = 0;
    int          done_seen = 0;
    int          last_pop_c = 0;
    int          first_valid_c = -1;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    bit          rdy;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(a + i) % DEPTH]);

    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 10'(a);
    req_len   = 16'(len);
    #1 check("req_ready_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;

    for (int c = 1; c <= 400 && done_seen == 0; c++) begin
      if (c > 1) @(negedge clk);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[(c - 1) % 6];
        2:       rdy = (c > 10);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      #1;
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid) check("beat_in_range", 64'(popped < len), 64'd1);
      if (mode == 0 && out_valid && first_valid_c < 0) begin
        first_valid_c = c;
        check("first_latency", 64'(c), 64'd3);
      end
      if (out_valid && out_ready && popped < len) begin
        check("beat_data", out_data, exp_q[popped]);
        check("beat_last", 64'(out_last), 64'(popped == len - 1));
        popped++;
        last_pop_c = c;
      end
      if (mem_read) begin
        check("over_issue", 64'(issued < len), 64'd1);
        check("issue_addr", 64'(mem_read_addr), 64'((a + issued) % DEPTH));
        issued++;
        check("occupancy", 64'((issued - popped) <= 2), 64'd1);
      end
      if (mode == 2 && c == 10) check("stall_issues", 64'(issued), 64'((len < 2) ? len : 2));
      if (done) begin
        check("done_timing", 64'(last_pop_c), 64'(c - 1));
        check("done_beats", 64'(popped), 64'(len));
        done_seen++;
      end
      check("req_ready_busy", 64'(req_ready), 64'(done));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (abort_after > 0 && popped == abort_after) return;
    end
    if (done_seen == 0) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    #1;
    check("done_once", 64'(done), 64'd0);
    check("idle_no_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b0;
    debugen   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) mem[i] = 64'(i) * 64'h0101;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_mem_addr", 64'(mem_read_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;

    run_burst(4, 4, 0, 0);
    run_burst(1022, 4, 0, 0);
    run_burst(0, 8, 1, 0);
    run_burst(5, 0, 0, 0);
    run_burst(2, 6, 2, 0);

    // Reset mid-burst with a read in flight.
    run_burst(20, 8, 0, 3);
    check("read_before_reset", 64'(mem_read), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_done", 64'(done), 64'd0);
    check("post_rst_read", 64'(mem_read), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("quiet_valid", 64'(out_valid), 64'd0);
      check("quiet_done", 64'(done), 64'd0);
    end
    run_burst(0, 2, 0, 0);

    for (int k = 0; k < 8; k++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)), 3, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Streaming read engine that sits directly in front of the byte-masked Memory block's read port. That block must be built with SHOWAHEAD=0, giving 1-cycle registered read latency.
- Accepts a burst request (start address, beat count) and drives the memory's read address and read strobe.
- Captures the returned words into a 2-entry skid buffer and presents them downstream on a valid/ready stream, with a last-beat marker and a completion pulse.
- Full-throughput (1 beat/cycle) under no backpressure; never drops or duplicates beats under arbitrary backpressure.

Parameters:
- MEM_WIDTH_BYTES, 8, memory word width in bytes; data width is MEM_WIDTH_BYTES*8.
- MEM_DEPTH, 1024, memory depth in words; address width AW = $clog2(MEM_DEPTH).
- LEN_WIDTH, 16, width of the burst beat-count field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid_in  in  1  burst request valid
- req_ready_out  out  1  engine idle, request accepted when valid&ready
- req_addr_in  in  AW  first word address
- req_len_in  in  LEN_WIDTH  number of beats (0 allowed)
- mem_read_addr_out  out  AW  to memory read_addr_in
- mem_read_out  out  1  to memory read_in, high on each issued read
- mem_read_data_in  in  MEM_WIDTH_BYTES*8  from memory read_data_out
- out_valid_out  out  1  stream beat valid
- out_ready_in  in  1  downstream accepts beat
- out_data_out  out  MEM_WIDTH_BYTES*8  beat data
- out_last_out  out  1  marks final beat of burst
- done_out  out  1  one-cycle pulse at burst completion
- debugen_in  in  1  enables per-cycle $write trace of request/issue/output activity

Behaviour:
- Reset values:
  - req_ready_out=1, mem_read_out=0, mem_read_addr_out=0.
  - out_valid_out=0, out_last_out=0, out_data_out=0, done_out=0.
  - Skid buffer empty, in-flight flag clear, state IDLE.
- States:
  - IDLE: req_ready_out=1. On req_valid_in with req_len_in>0: latch addr and remaining=len, go ISSUE. With req_len_in=0: go IDLE and pulse done_out the next cycle; no beats are produced.
  - ISSUE: issue reads while remaining>0. Go DRAIN in the cycle the last read issues.
  - DRAIN: wait until the in-flight flag is clear and the buffer is empty. done_out pulses in the cycle after the last beat handshakes; the engine is IDLE (req_ready_out=1) in that same cycle.
- Issue rule (combinational mem_read_out):
  - Condition: state==ISSUE and (count + inflight - pop) < 2, where pop = out_valid_out & out_ready_in.
  - On issue: mem_read_addr_out = current address; address += 1 modulo MEM_DEPTH (MEM_DEPTH-1 wraps to 0); remaining -= 1; inflight set for the next cycle.
- Capture:
  - If inflight is set, mem_read_data_in is written into the buffer tail this cycle. Data corresponds to the address issued in the previous cycle.
  - The buffer never overflows by construction.
  - The entry holding the burst's final word carries last=1.
- Output:
  - out_valid_out = count>0; out_data_out and out_last_out come from the head entry.
  - Data and last stay stable while valid && !ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Throughput:
  - With out_ready_in held at 1, the first beat is valid 2 cycles after request acceptance (issue at t+1, capture at t+2), then 1 beat/cycle.
  - The last beat is followed by done_out 1 cycle after its handshake.
- Backpressure: with out_ready_in=0, at most 2 reads are outstanding/buffered, and issue stalls. On resume, beats continue in address order.
- Requests are not queued; req_ready_out=0 outside IDLE.
- Reset mid-burst: all state returns to reset values the next cycle. A read issued in the reset cycle is discarded. No stale beat or done_out appears after reset.
- Arithmetic: remaining is LEN_WIDTH bits; the maximum burst is 2^LEN_WIDTH-1 beats. The address counter is AW bits with explicit modulo-MEM_DEPTH wrap (MEM_DEPTH need not be a power of 2).

Test Plan:
- Preload mem[i]=i*0x0101 for i=0..15. Request addr=4, len=4, out_ready_in=1. Expect out_data 0x0404, 0x0505, 0x0606, 0x0707 on consecutive cycles starting 2 cycles after acceptance. out_last only on 0x0707; done_out 1 cycle later.
- MEM_DEPTH=1024, request addr=1022, len=4. Expect mem_read_addr_out sequence 1022, 1023, 0, 1 and beats in the same order.
- Request len=8 with out_ready_in toggling 1,0,0,1,0,1… Expect exactly 8 beats in address order, no duplicates. mem_read_out never raised when count+inflight-pop>=2. Data held stable during stalls.
- Request len=0. Expect no out_valid_out, done_out pulse 1 cycle after acceptance, req_ready_out stays 1.
- Request len=6, out_ready_in=0 for 10 cycles. Expect exactly 2 reads issued, then stall. Release ready: remaining 6 beats delivered, done_out once.
- Assert reset for 1 cycle mid-burst (after 3 of 8 beats), with a read in flight. Next cycle: out_valid_out=0, req_ready_out=1, done_out=0. A new request addr=0, len=2 then returns mem[0], mem[1] only.
